// File: rtl/mod_n_updown_cnt.sv
// mod_n_updown_cnt: parametrised modulo-N up/down counter with load and flags.
// Build option MODCNT_SAT_EN: saturate at the range ends instead of wrapping.
module mod_n_updown_cnt #(
  parameter int unsigned      WIDTH   = 7,
  parameter longint unsigned  MODULUS = 99,
  parameter longint unsigned  INIT    = MODULUS - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST   = WIDTH'(INIT);

  logic [WIDTH-1:0] cy;
  logic [WIDTH-1:0] bw;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;

  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;

  // Ripple chains; the carry/borrow out of the top bit is dropped.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rip
    assign inc[i] = count[i] ^ cy[i];
    assign dec[i] = count[i] ^ bw[i];
    if (i < WIDTH - 1) begin : g_link
      assign cy[i+1] = count[i] & cy[i];
      assign bw[i+1] = ~count[i] & bw[i];
    end
  end

  logic at_top;
  logic at_bot;
  logic load_ok;

  assign at_top  = (count == TOP);
  assign at_bot  = (count == '0);
  assign load_ok = ({1'b0, load_val} < MOD_X);

  logic [WIDTH-1:0] up_nx;
  logic [WIDTH-1:0] dn_nx;
  logic             end_wrap;

`ifdef MODCNT_SAT_EN
  assign up_nx    = at_top ? TOP : inc;
  assign dn_nx    = at_bot ? '0  : dec;
  assign end_wrap = 1'b0;
`else
  assign up_nx    = at_top ? '0  : inc;
  assign dn_nx    = at_bot ? TOP : dec;
  assign end_wrap = 1'b1;
`endif

  logic             do_up;
  logic             do_dn;
  logic [WIDTH-1:0] cnt_nx;
  logic             wrap_nx;
  logic             err_nx;

  assign do_up = ~load & en & up_dn;
  assign do_dn = ~load & en & ~up_dn;

  always_comb begin
    cnt_nx  = count;
    wrap_nx = 1'b0;
    err_nx  = 1'b0;
    unique case (1'b1)
      load: begin
        if (load_ok) cnt_nx = load_val;
        else         err_nx = 1'b1;
      end
      do_up: begin
        cnt_nx  = up_nx;
        wrap_nx = end_wrap & at_top;
      end
      do_dn: begin
        cnt_nx  = dn_nx;
        wrap_nx = end_wrap & at_bot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= RST;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= cnt_nx;
      wrap     <= wrap_nx;
      load_err <= err_nx;
    end
  end

  // Cascade enable for the next stage; deliberately blind to load.
  assign tc = en & ((up_dn & at_top) | (~up_dn & at_bot));

endmodule
